// File: rtl/pipe_reg_de_pkg.sv
// Shared CPU definitions for the D->E pipeline register: RegDst encodings,
// bubble instruction, reset PC and hazard-timing width.
package cpu_defs;

   localparam logic [1:0]  REGDST_RD = 2'b00;
   localparam logic [1:0]  REGDST_RT = 2'b01;
   localparam logic [1:0]  REGDST_RA = 2'b10;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] RESET_PC  = 32'h0000_3000;

   localparam int          TNEW_W    = 2;

   // Tnew counts from D, so one stage later it is one less, never below zero.
   function automatic logic [TNEW_W-1:0] tnewDec(input logic [TNEW_W-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// One pipeline-register field: async reset and synchronous clear both load
// RST_VAL, clear outranks enable, and a deasserted enable holds the value.
module pipe_field_reg
   import cpu_defs::*;
#(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr)
         q_d = RST_VAL;
      else if (en)
         q_d = d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q_q <= RST_VAL;
      else
         q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/pipe_reg_de.sv
// Decode-to-Execute pipeline register: loads D fields, inserts bubbles on D
// stalls, clears on flush, freezes while E is busy, and counts bubbles.
module pipe_reg_de
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
   parameter int          CNT_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_D,
   input  logic              hold_E,
   input  logic              flush,
   input  logic [31:0]       Instr_D,
   input  logic [31:0]       PC_D,
   input  logic [31:0]       RD1_D,
   input  logic [31:0]       RD2_D,
   input  logic [31:0]       EXT_D,
   input  logic [1:0]        RegDst_D,
   input  logic [TNEW_W-1:0] Tnew_D,
   output logic [31:0]       Instr_E,
   output logic [31:0]       PC_E,
   output logic [31:0]       RD1_E,
   output logic [31:0]       RD2_E,
   output logic [31:0]       EXT_E,
   output logic [4:0]        Rs_E,
   output logic [4:0]        Rt_E,
   output logic [4:0]        Rd_E,
   output logic [1:0]        RegDst_E,
   output logic [TNEW_W-1:0] Tnew_E,
   output logic              valid_E,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // Flush always clears; a stall clears only when E is free to advance,
   // otherwise the held instruction would be lost.
   logic fieldClr;
   logic fieldEn;
   logic bubbleIns;

   assign bubbleIns = stall_D & ~hold_E & ~flush;
   assign fieldClr  = flush | (stall_D & ~hold_E);
   assign fieldEn   = ~hold_E;

   pipe_field_reg #(.WIDTH(32), .RST_VAL(NOP_INSTR)) uInstr (
      .clk(clk), .reset(reset), .clr(fieldClr), .en(fieldEn), .d(Instr_D), .q(Instr_E));

   pipe_field_reg #(.WIDTH(32), .RST_VAL(32'h0)) uRd1 (
      .clk(clk), .reset(reset), .clr(fieldClr), .en(fieldEn), .d(RD1_D), .q(RD1_E));

   pipe_field_reg #(.WIDTH(32), .RST_VAL(32'h0)) uRd2 (
      .clk(clk), .reset(reset), .clr(fieldClr), .en(fieldEn), .d(RD2_D), .q(RD2_E));

   pipe_field_reg #(.WIDTH(32), .RST_VAL(32'h0)) uExt (
      .clk(clk), .reset(reset), .clr(fieldClr), .en(fieldEn), .d(EXT_D), .q(EXT_E));

   pipe_field_reg #(.WIDTH(2), .RST_VAL(REGDST_RD)) uRegDst (
      .clk(clk), .reset(reset), .clr(fieldClr), .en(fieldEn), .d(RegDst_D), .q(RegDst_E));

   pipe_field_reg #(.WIDTH(TNEW_W), .RST_VAL('0)) uTnew (
      .clk(clk), .reset(reset), .clr(fieldClr), .en(fieldEn), .d(tnewDec(Tnew_D)), .q(Tnew_E));

   pipe_field_reg #(.WIDTH(1), .RST_VAL(1'b0)) uValid (
      .clk(clk), .reset(reset), .clr(fieldClr), .en(fieldEn), .d(1'b1), .q(valid_E));

   // PC follows D even through a bubble so a later exception still sees a
   // meaningful EPC; only a flush sends it back to the reset vector.
   logic [31:0]      pcE_q;
   logic [31:0]      pcE_d;
   logic [CNT_W-1:0] bubbleCnt_q;
   logic [CNT_W-1:0] bubbleCnt_d;

   always_comb begin
      pcE_d       = pcE_q;
      bubbleCnt_d = bubbleCnt_q;
      if (flush)
         pcE_d = RESET_PC;
      else if (!hold_E)
         pcE_d = PC_D;
      if (bubbleIns)
         bubbleCnt_d = bubbleCnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcE_q       <= RESET_PC;
         bubbleCnt_q <= '0;
      end else begin
         pcE_q       <= pcE_d;
         bubbleCnt_q <= bubbleCnt_d;
      end
   end

   assign PC_E       = pcE_q;
   assign bubble_cnt = bubbleCnt_q;

   assign Rs_E = Instr_E[25:21];
   assign Rt_E = Instr_E[20:16];
   assign Rd_E = Instr_E[15:11];

endmodule
